// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, funct3 decode constants and byte-enable helper for the memory-stage LSU
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return (funct3 inside {F3_B, F3_BU}) ? 4'b0001 << addr_lo :
           (funct3 inside {F3_H, F3_HU}) ? 4'b0011 << addr_lo : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend: picks the addressed byte/half lane of a read word and sign/zero extends it
module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*addr_lo +: 8];
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    ext = funct3[1:0] == 2'b00 ? {{24{~funct3[2] & b[7]}}, b} :
          funct3[1:0] == 2'b01 ? {{16{~funct3[2] & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: single-outstanding req/ack load/store unit stalling the pipeline until completion
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_readM_i,
  input  logic                     mem_writeM_i,
  input  logic [2:0]               funct3M_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
  input  logic [DATA_WIDTH-1:0]    write_dataM_i,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [ADDRESS_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0]    bus_wdata_o,
  output logic [3:0]               bus_be_o,
  input  logic                     bus_ack_i,
  input  logic [DATA_WIDTH-1:0]    bus_rdata_i,
  output logic [DATA_WIDTH-1:0]    read_dataM_o,
  output logic                     stall_o,
  output logic                     fault_o
);
  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  lsu_state_t state, state_n;
  logic is_op, legal, aligned, go, bad, ack, tmo;
  logic [2:0] f3_q;
  logic [1:0] alo_q;
  logic [DATA_WIDTH-1:0] ext;
  assign is_op   = mem_readM_i | mem_writeM_i;
  assign legal   = mem_writeM_i ? funct3M_i inside {F3_B, F3_H, F3_W}
                                : funct3M_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign aligned = funct3M_i[1:0] == 2'b01 ? ~alu_resultM_i[0] :
                   funct3M_i[1:0] == 2'b10 ? alu_resultM_i[1:0] == 2'b00 : 1'b1;
  assign go      = state == IDLE && is_op && legal && aligned;
  assign bad     = state == IDLE && is_op && !(legal && aligned);
  assign ack     = state == BUSY && bus_ack_i;
  assign stall_o = ~rst_i & (go | state == BUSY);
`ifdef LSU_TIMEOUT_EN
  logic [31:0] cnt;
  assign tmo = state == BUSY && !bus_ack_i && cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    if (rst_i || go) cnt <= '0;
    else if (state == BUSY) cnt <= cnt + 32'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb
    state_n = state == IDLE ? (go ? BUSY : IDLE) :
              state == BUSY ? (ack || tmo ? DONE : BUSY) : IDLE;
  load_extend u_ext (.rdata(bus_rdata_i), .addr_lo(alo_q), .funct3(f3_q), .ext(ext));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state        <= IDLE;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      bus_be_o     <= '0;
      read_dataM_o <= '0;
      fault_o      <= 1'b0;
      f3_q         <= '0;
      alo_q        <= '0;
    end else begin
      state   <= state_n;
      fault_o <= bad | tmo;
      if (go) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_writeM_i;
        bus_addr_o  <= {alu_resultM_i[ADDRESS_WIDTH-1:2], 2'b00};
        bus_be_o    <= be_for(funct3M_i, alu_resultM_i[1:0]);
        bus_wdata_o <= funct3M_i[1:0] == 2'b00 ? {4{write_dataM_i[7:0]}} :
                       funct3M_i[1:0] == 2'b01 ? {2{write_dataM_i[15:0]}} : write_dataM_i;
        f3_q        <= funct3M_i;
        alo_q       <= alu_resultM_i[1:0];
      end
      if (bad || tmo) read_dataM_o <= '0;
      if (ack) begin
        bus_req_o <= 1'b0;
        if (!bus_we_o) read_dataM_o <= ext;
      end
      if (tmo) bus_req_o <= 1'b0;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit for the 5-stage pipeline.
- Sits between the execute→memory pipeline register and the memory→writeback register.
- Produces read_dataM for writeback.
- Drives a single-outstanding request/acknowledge data bus; stalls the pipeline until the access completes.
- Handles byte/half/word lane steering, byte enables, and load sign/zero extension.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
TIMEOUT_CYCLES, 16, max BUSY cycles before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_readM_i  in  1  load in M stage
mem_writeM_i  in  1  store in M stage
funct3M_i  in  3  access size/sign (RV32I encoding)
alu_resultM_i  in  ADDRESS_WIDTH  byte address
write_dataM_i  in  DATA_WIDTH  store data (rs2)
bus_req_o  out  1  request valid
bus_we_o  out  1  1 = write
bus_addr_o  out  ADDRESS_WIDTH  word-aligned address (bits [1:0] = 0)
bus_wdata_o  out  DATA_WIDTH  lane-steered store data
bus_be_o  out  4  byte enables
bus_ack_i  in  1  responder done; rdata valid this cycle
bus_rdata_i  in  DATA_WIDTH  read word
read_dataM_o  out  DATA_WIDTH  extended load result
stall_o  out  1  hold IF/ID/EX/M registers
fault_o  out  1  one-cycle pulse: misaligned/illegal access (or timeout)

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE; bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, read_dataM_o, fault_o all 0. stall_o is 0 while rst_i is high.
- Registered outputs: all bus_* outputs and read_dataM_o.
- Combinational output: stall_o.
- Access decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Op priority: if mem_readM_i and mem_writeM_i are both high, the store wins.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No op: stay in IDLE; stall_o=0.
  - Legal, aligned op:
    - Combinationally, stall_o=1.
    - At the edge: latch addr, be, wdata, we, funct3; set bus_req_o=1; go to BUSY.
  - Misaligned or illegal op:
    - No bus access; stall_o=0.
    - At the edge: fault_o=1 for one cycle; read_dataM_o=0; stay in IDLE.
- BUSY:
  - stall_o=1.
  - bus_req_o and all bus_* outputs are held stable until bus_ack_i.
  - On bus_ack_i:
    - Loads: read_dataM_o ← extended bus_rdata_i.
    - Stores: read_dataM_o is unchanged.
    - bus_req_o ← 0; go to DONE.
- DONE:
  - stall_o=0, so the pipeline advances this edge.
  - Next state is unconditionally IDLE; an op presented in DONE is the finished one and is ignored.
- bus_ack_i outside BUSY is ignored.
- Minimum latency: op seen at cycle 0, request at cycle 1, ack at cycle 1, DONE and result at cycle 2. 3 cycles total, 2 stall cycles.
- Byte enables (k = addr[1:0]):
  - SB/LB/LBU: be = 1<<k.
  - SH/LH/LHU: be = 0011 << k.
  - SW/LW: be = 1111.
- Store data: wdata = byte/half replicated across all lanes.
- Load extraction: lane k. LB/LH sign-extend; LBU/LHU zero-extend.
- read_dataM_o holds its value until the next completed load or fault.
- Reset while BUSY: returns to IDLE at that edge; bus_req_o=0 next cycle; a late ack is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - Counter starts at 0 on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: bus_req_o←0, read_dataM_o←0, fault_o pulse, go to DONE.
  - Ack in that same cycle takes precedence (normal completion, no fault).
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - State enum lsu_state_t {IDLE, BUSY, DONE}.
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function be_for(funct3, addr_lo).
- Sub-module load_extend (combinational): inputs rdata, addr[1:0], funct3; output extended word.

Test Plan:
- LW at addr 0x100, ack 1 cycle after req → bus_addr_o=0x100, be=1111; stall_o high for 2 cycles; read_dataM_o=bus_rdata_i=0xDEADBEEF.
- LB at 0x103, rdata 0x80FF_FF00 → be=1000; read_dataM_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, write_data 0x0000ABCD, ack after 3 wait cycles → bus_we_o=1, be=1100, bus_wdata_o=0xABCDABCD; bus_* stable throughout; stall for 4 cycles.
- LW at 0x101 → no bus_req_o, fault_o pulse, stall_o=0, read_dataM_o=0.
- rst_i high while BUSY, then ack next cycle → state IDLE, bus_req_o=0, read_dataM_o=0; ack ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack → DONE after 16 BUSY cycles; fault_o=1; read_dataM_o=0.
